instruction_fetch_unit: RTL and testbench

//   Fetch stage feeding the control unit's decode/execute logic. Drives word

---
 rtl/instruction_fetch_unit_pkg.sv | 15 +
 rtl/instruction_fetch_unit_fetch_fifo.sv | 59 +++++
 rtl/instruction_fetch_unit.sv | 78 +++++++
 tb/tb_instruction_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch/decode constants: default word and address widths, reset PC,
// and instruction field positions reused by the decode stage.
package instruction_fetch_unit_pkg;

    localparam int LIMB_WORD_W = 32;
    localparam int LIMB_ADDR_W = 32;
    localparam logic [LIMB_ADDR_W-1:0] LIMB_RESET_PC = '0;

    // Condition and opcode fields of an instruction word.
    localparam int LIMB_COND_MSB   = 31;
    localparam int LIMB_COND_LSB   = 28;
    localparam int LIMB_OPCODE_MSB = 27;
    localparam int LIMB_OPCODE_LSB = 24;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush and occupancy count.
// The head entry is read straight from storage and reads as zero when empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);

    // Flush wins over push and pop; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues sequential word reads to a synchronous RAM, tags each
// returned word with its PC, buffers it and hands it to decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = LIMB_ADDR_W,
    parameter int                    DATA_WIDTH = LIMB_WORD_W,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = LIMB_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_rw,
    output logic                  mem_req,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0]            pc;
    logic                             inflight;
    logic [ADDR_WIDTH-1:0]            inflight_pc;
    logic [CW-1:0]                    fifo_count;
    logic [CW:0]                      occupied;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

    // A FIFO slot is reserved at issue time, so buffered plus in-flight words never exceed DEPTH.
    assign occupied = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign mem_req  = !rst && !redirect && (occupied < (CW+1)'(DEPTH));
    assign mem_a    = pc;
    assign mem_rw   = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_req;
            if (mem_req) begin
                inflight_pc <= pc;
                pc          <= pc + 1'b1;
            end
        end
    end

    // Output handshake: the head entry transfers on any edge where inst_valid and
    // inst_ready are both high; while inst_valid is high and inst_ready low,
    // inst/inst_pc hold. A redirect flushes the buffer but a transfer in that
    // same cycle still counts as consumed.
    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight && !redirect),
        .push_data ({inflight_pc, mem_dout}),
        .pop       (inst_valid && inst_ready),
        .flush     (redirect),
        .head_data (head),
        .count     (fifo_count)
    );

    assign inst_valid      = (fifo_count != '0);
    assign {inst_pc, inst} = head;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized phase scored against a stream-level model of expected fetches.
module tb_instruction_fetch_unit;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] mem_a;
    logic          mem_rw;
    logic          mem_req;
    logic [DW-1:0] mem_dout = '0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;

    instruction_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RESET_PC   ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_a       (mem_a),
        .mem_rw      (mem_rw),
        .mem_req     (mem_req),
        .mem_dout    (mem_dout),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return a + 32'h100;
    endfunction

    always @(posedge clk) begin
        if (mem_req) mem_dout <= word_at(mem_a);
    end

    // ---------------- scoreboard ----------------
    int            n_total = 0;
    int            n_bad   = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] issue_pc;
    int            n_issue;
    int            n_acc;
    int            n_acc_pc5;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        issue_pc = '0;
    endtask

    // One clock: score the cycle's outputs, advance the model, step past the edge.
    task automatic tick();
        logic            exp_req;
        logic            held;
        logic [AW+DW:0]  held_v;
        logic [AW-1:0]   epc;
        #1;
        exp_req = !rst && !redirect && (exp_q.size() < DEPTH);
        check_eq("mem_req", mem_req, exp_req);
        if (exp_req) check_eq("mem_a", mem_a, issue_pc);
        check_eq("mem_rw", mem_rw, 0);
        if (mem_req) n_issue++;
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("inst_valid_idle", inst_valid, 0);
            end else begin
                epc = exp_q.pop_front();
                check_eq("inst_pc", inst_pc, epc);
                check_eq("inst", inst, word_at(epc));
                n_acc++;
                if (inst_pc == 32'd5) n_acc_pc5++;
            end
        end
        held   = inst_valid && !inst_ready && !redirect && !rst;
        held_v = {inst_valid, inst_pc, inst};
        if (redirect && !rst) begin
            exp_q.delete();
            issue_pc = redirect_pc;
        end else if (exp_req) begin
            exp_q.push_back(issue_pc);
            issue_pc++;
        end
        @(posedge clk);
        #1;
        if (held && !rst) check_eq("hold_stable", {inst_valid, inst_pc, inst}, held_v);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_inst", inst, 0);
        check_eq("rst_inst_pc", inst_pc, 0);
        check_eq("rst_mem_rw", mem_rw, 0);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;

        // 1: streaming, two-cycle latency, one per cycle
        do_reset();
        inst_ready = 1'b1;
        tick();
        check_eq("t1_lat_c1", inst_valid, 0);
        tick();
        check_eq("t1_first_inst", inst, 32'h100);
        for (int i = 0; i < 10; i++) begin
            check_eq("t1_stream", {inst_valid, inst_pc}, {1'b1, 32'(i)});
            tick();
        end

        // 2: backpressure holds after exactly DEPTH reads
        do_reset();
        n_issue = 0;
        repeat (10) tick();
        check_eq("t2_issue_cnt", n_issue, 4);
        check_eq("t2_mem_req", mem_req, 0);
        check_eq("t2_head", {inst_valid, inst_pc, inst}, {1'b1, 32'd0, 32'h100});
        inst_ready = 1'b1;
        n_acc = 0;
        repeat (12) tick();
        check_eq("t2_drained", n_acc > 8, 1);

        // 3: redirect with 3 buffered and 1 in flight
        do_reset();
        repeat (4) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        check_eq("t3_r1_valid", inst_valid, 0);
        tick();
        check_eq("t3_r2_valid", inst_valid, 0);
        tick();
        check_eq("t3_r3", {inst_valid, inst_pc}, {1'b1, 32'h20});
        tick();
        check_eq("t3_r4", {inst_valid, inst_pc}, {1'b1, 32'h21});
        repeat (4) tick();

        // 4: redirect in the same cycle as the handshake of pc 5
        do_reset();
        inst_ready = 1'b1;
        n_acc_pc5  = 0;
        found      = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inst_valid && inst_pc == 32'd5) found = 1'b1;
            else tick();
        end
        check_eq("t4_found_pc5", found, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        check_eq("t4_target", {inst_valid, inst_pc}, {1'b1, 32'h40});
        repeat (3) tick();
        check_eq("t4_pc5_once", n_acc_pc5, 1);

        // 5: asynchronous reset mid-stream
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_async_valid", inst_valid, 0);
        check_eq("t5_async_req", mem_req, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        check_eq("t5_restart", {inst_valid, inst_pc}, {1'b1, 32'd0});

        // 6: redirect to the last address wraps to 0
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        check_eq("t6_top", {inst_valid, inst_pc, inst}, {1'b1, 32'hFFFF_FFFF, 32'h0000_00FF});
        tick();
        check_eq("t6_wrap", {inst_valid, inst_pc}, {1'b1, 32'h0});
        repeat (3) tick();

        // randomized traffic with backpressure, redirects and one reset
        n_acc = 0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            inst_ready = ($urandom_range(0, 99) < 70);
            redirect   = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFFE;
            else redirect_pc = $urandom;
            tick();
        end
        redirect = 1'b0;
        check_eq("rand_progress", n_acc > 100, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
